floor_request_panel: RTL
========================

FLOOR_REQUEST_PANEL -- requirements
Module: floor_request_panel

Interface
REQ-001 Parameter DOOR_CYCLES, default 4: number of cycles door_open stays high per stop, range 1..15.
REQ-002 Parameter TRAVEL_LIMIT, default 16: maximum cycles allowed in TRAVEL before fault, range 4..255.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 press  input  4  momentary floor call buttons, bit k = floor k, any number may be high in one cycle.
REQ-006 position  input  2  current car floor, as reported by the elevator controller.
REQ-007 button0..button3  output  1 each  floor command lines to the elevator controller, at most one high per cycle.
REQ-008 pending  output  4  latched unserved calls, bit k = floor k.
REQ-009 door_open  output  1  high while the car dwells at a served floor.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 fault  output  1  sticky travel-watchdog error flag.

Function
REQ-012 States: IDLE, TRAVEL, DOOR, FAULT; all outputs registered.
REQ-013 pending bit k is set on the clock edge after press[k] is sampled high; it is cleared only on arrival at floor k or reset.
REQ-014 Press on floor k with position==k while state is IDLE or DOOR does not set pending[k]: in IDLE it enters DOOR next cycle; in DOOR it reloads the dwell counter to DOOR_CYCLES.
REQ-015 Direction register dir (up=1) selects the target: nearest pending floor strictly ahead in dir; if none, reverse dir and take nearest pending floor in the new direction.
REQ-016 IDLE -> TRAVEL on the cycle after pending becomes non-zero; target is latched on that transition and held fixed until arrival.
REQ-017 In TRAVEL, button<target> is high and all other button outputs are low; all buttons are low in IDLE, DOOR and FAULT.
REQ-018 Arrival: position==target sampled in TRAVEL -> next cycle state DOOR, pending[target] cleared, door_open high, button outputs low.
REQ-019 DOOR lasts exactly DOOR_CYCLES cycles (absent REQ-014 reloads); then IDLE if pending==0, else TRAVEL directly with a new target per REQ-015.
REQ-020 Presses arriving in TRAVEL for floors other than target only set pending; they do not change the latched target.
REQ-021 Travel counter resets on entry to TRAVEL and increments each TRAVEL cycle; reaching TRAVEL_LIMIT -> FAULT next cycle.
REQ-022 FAULT: fault=1, busy=1, buttons low, door_open low, pending continues to latch presses; exits only via reset.
REQ-023 Simultaneous press[k] and arrival at k in the same cycle: arrival clear wins, pending[k] ends 0.

Reset
REQ-024 reset=1 on a clock edge forces state IDLE, pending=0, dir=up, counters=0, all buttons=0, door_open=0, busy=0, fault=0, regardless of current state.
REQ-025 press sampled during a reset cycle is discarded.
REQ-026 Reset asserted mid-TRAVEL or mid-DOOR drops buttons and door_open on that same edge.

Verification
REQ-027 Reset, position=0, press=0100 for 1 cycle -> pending=0100 next cycle, busy and button2 high the cycle after; car reaches 2 -> door_open high 4 cycles, pending=0000, then IDLE.
REQ-028 position=1, IDLE, press=0010 -> pending stays 0000, door_open high 4 cycles; second press=0010 at door cycle 3 -> door_open extended to 4 cycles from reload.
REQ-029 position=1, dir=up, pending=1001 -> target 3 first, then dir reverses, target 0; button3 then button0 observed in order.
REQ-030 TRAVEL with position held at 0 toward target 2 -> fault=1 after 16 TRAVEL cycles, buttons low, fault persists until reset.
REQ-031 Reset asserted during DOOR with pending=1010 -> next cycle all outputs 0, state IDLE.
REQ-032 press[2] and arrival at floor 2 in the same cycle -> pending[2]=0, door_open high next cycle.

Source files
------------

// File: rtl/floor_request_panel.sv
// Floor call panel: latches button presses, picks the next floor in the
// current sweep direction, drives one floor command line and dwells with door open.
module floor_request_panel #(
  parameter int DOOR_CYCLES  = 4,
  parameter int TRAVEL_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] press,
  input  logic [1:0] position,
  output logic       button0,
  output logic       button1,
  output logic       button2,
  output logic       button3,
  output logic [3:0] pending,
  output logic       door_open,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRAVEL = 2'd1,
    S_DOOR   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic        dir_q, dir_d;
  logic [1:0]  target_q, target_d;
  logic [3:0]  door_cnt_q, door_cnt_d;
  logic [7:0]  travel_cnt_q, travel_cnt_d;
  logic [3:0]  button_q, button_d;
  logic        door_open_q, door_open_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;

  logic [2:0]  sel;
  logic [8:0]  travel_inc;
  logic [3:0]  here_mask;
  logic        local_hit;

  // Returns {new_dir, target}: nearest pending floor ahead, else reverse.
  // With nothing ahead either way, the current floor is returned.
  function automatic logic [2:0] pick_target(input logic [3:0] pend,
                                             input logic [1:0] pos,
                                             input logic       dir);
    logic       found_up, found_dn;
    logic [1:0] up_t, dn_t;
    found_up = 1'b0;
    found_dn = 1'b0;
    up_t     = pos;
    dn_t     = pos;
    for (int f = 3; f >= 0; f--) begin
      if (f > int'(pos) && pend[f]) begin
        found_up = 1'b1;
        up_t     = 2'(f);
      end
    end
    for (int f = 0; f <= 3; f++) begin
      if (f < int'(pos) && pend[f]) begin
        found_dn = 1'b1;
        dn_t     = 2'(f);
      end
    end
    if (dir) begin
      if (found_up)      pick_target = {1'b1, up_t};
      else if (found_dn) pick_target = {1'b0, dn_t};
      else               pick_target = {dir, pos};
    end else begin
      if (found_dn)      pick_target = {1'b0, dn_t};
      else if (found_up) pick_target = {1'b1, up_t};
      else               pick_target = {dir, pos};
    end
  endfunction

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | press;
    dir_d        = dir_q;
    target_d     = target_q;
    door_cnt_d   = door_cnt_q;
    travel_cnt_d = travel_cnt_q;
    here_mask    = 4'b0001 << position;
    local_hit    = press[position];
    sel          = pick_target(pending_q, position, dir_q);
    travel_inc   = {1'b0, travel_cnt_q} + 9'd1;

    case (state_q)
      S_IDLE: begin
        // A call at the floor the car already sits on just opens the door.
        pending_d = pending_q | (press & ~here_mask);
        if (local_hit) begin
          state_d    = S_DOOR;
          door_cnt_d = 4'(DOOR_CYCLES);
        end else if (pending_q != 4'b0000) begin
          state_d      = S_TRAVEL;
          target_d     = sel[1:0];
          dir_d        = sel[2];
          travel_cnt_d = 8'd0;
        end
      end
      S_TRAVEL: begin
        travel_cnt_d = travel_inc[7:0];
        if (position == target_q) begin
          state_d             = S_DOOR;
          pending_d[target_q] = 1'b0;
          door_cnt_d          = 4'(DOOR_CYCLES);
        end else if (travel_inc == 9'(TRAVEL_LIMIT)) begin
          state_d = S_FAULT;
        end
      end
      S_DOOR: begin
        pending_d = pending_q | (press & ~here_mask);
        if (local_hit) begin
          door_cnt_d = 4'(DOOR_CYCLES);
        end else if (door_cnt_q <= 4'd1) begin
          door_cnt_d = 4'd0;
          if (pending_q == 4'b0000) begin
            state_d = S_IDLE;
          end else begin
            state_d      = S_TRAVEL;
            target_d     = sel[1:0];
            dir_d        = sel[2];
            travel_cnt_d = 8'd0;
          end
        end else begin
          door_cnt_d = door_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    button_d    = (state_d == S_TRAVEL) ? (4'b0001 << target_d) : 4'b0000;
    door_open_d = (state_d == S_DOOR);
    busy_d      = (state_d != S_IDLE);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pending_q    <= 4'b0000;
      dir_q        <= 1'b1;
      target_q     <= 2'd0;
      door_cnt_q   <= 4'd0;
      travel_cnt_q <= 8'd0;
      button_q     <= 4'b0000;
      door_open_q  <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      dir_q        <= dir_d;
      target_q     <= target_d;
      door_cnt_q   <= door_cnt_d;
      travel_cnt_q <= travel_cnt_d;
      button_q     <= button_d;
      door_open_q  <= door_open_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  assign button0   = button_q[0];
  assign button1   = button_q[1];
  assign button2   = button_q[2];
  assign button3   = button_q[3];
  assign pending   = pending_q;
  assign door_open = door_open_q;
  assign busy      = busy_q;
  assign fault     = fault_q;

endmodule
